plic_mc_core: RTL and testbench

- Parametrised PLIC core: interrupt gateways, pending array, priority arbiter and claim/complete logic for NUM_CONTEXTS hart contexts.
- Sits behind the uncore register bus at PLIC_BASE_ADDR. Drives one external-interrupt line per context into the core(s).
- Adds features the previous single-context, level-only PLIC did not have:
  - multiple contexts
  - per-source level/edge mode
  - edge counting
  - registered arbitration

---
 rtl/plic_mc_core.sv | 171 +++++++++++++++++
 tb/tb_plic_mc_core.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/plic_mc_core.sv
`default_nettype none
// ----------------------------------------------------------------------------
// plic_mc_core : multi-context PLIC core with level/edge gateways and claim/complete
// Rev 1.0
// ----------------------------------------------------------------------------
module plic_mc_core #(
  parameter int          NUM_SOURCES  = 6,
  parameter int          NUM_CONTEXTS = 1,
  parameter int          PRIO_W       = 3,
  parameter logic [31:0] EDGE_MASK    = 32'd0,
  parameter int          EDGE_CNT_W   = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_SOURCES:0]    irq_src_i,
  input  logic                    bus_sel_i,
  input  logic                    bus_we_i,
  input  logic [23:0]             bus_addr_i,
  input  logic [31:0]             bus_wdata_i,
  output logic [31:0]             bus_rdata_o,
  output logic                    bus_ack_o,
  output logic [NUM_CONTEXTS-1:0] irq_o
);

  localparam int NS = NUM_SOURCES;
  localparam int NC = NUM_CONTEXTS;
  localparam logic [EDGE_CNT_W-1:0] CNT_MAX = '1;

  logic [PRIO_W-1:0]     prio     [1:NS];
  logic [EDGE_CNT_W-1:0] cnt      [1:NS];
  logic [EDGE_CNT_W-1:0] cnt_next [1:NS];
  logic [NS:1]           pending, inflight, src_q, rise;
  logic [NS:1]           set_pend, claim_bit, done_bit;
  logic [NS:1]           enable   [NC];
  logic [PRIO_W-1:0]     thr      [NC];
  logic [4:0]            max_id   [NC];
  logic [4:0]            win_id   [NC];
  logic [PRIO_W-1:0]     win_prio [NC];
  logic [4:0]            claim_id;
  logic [31:0]           rdata_next;
  logic                  unused_bits;

  // Address decode
  logic [9:0] prio_idx;
  logic [4:0] en_ctx;
  logic [2:0] hi_ctx;
  logic       sel_prio, sel_pend, sel_en, sel_thr, sel_claim;

  assign prio_idx  = bus_addr_i[11:2];
  assign en_ctx    = bus_addr_i[11:7];
  assign hi_ctx    = bus_addr_i[14:12];
  assign sel_prio  = (bus_addr_i[23:12] == 12'h000) && (prio_idx >= 10'd1) && (prio_idx <= 10'(NS));
  assign sel_pend  = (bus_addr_i == 24'h001000);
  assign sel_en    = (bus_addr_i[23:12] == 12'h002) && (bus_addr_i[6:0] == 7'd0) && (en_ctx < 5'(NC));
  assign sel_thr   = (bus_addr_i[23:15] == 9'h040) && (bus_addr_i[11:0] == 12'h000) && ({1'b0, hi_ctx} < 4'(NC));
  assign sel_claim = (bus_addr_i[23:15] == 9'h040) && (bus_addr_i[11:0] == 12'h004) && ({1'b0, hi_ctx} < 4'(NC));

  assign rise        = irq_src_i[NS:1] & ~src_q;
  assign unused_bits = ^{irq_src_i[0], bus_wdata_i};

  // Arbiter: starting the running best at the threshold makes "priority > threshold"
  // implicit, and a strict compare in ascending ID order gives ties to the lowest ID.
  always_comb begin
    for (int c = 0; c < NC; c++) begin
      win_id[c]   = 5'd0;
      win_prio[c] = thr[c];
      for (int i = 1; i <= NS; i++) begin
        if (pending[i] && enable[c][i] && (prio[i] > win_prio[c])) begin
          win_id[c]   = 5'(i);
          win_prio[c] = prio[i];
        end
      end
    end
  end

  // Gateways
  always_comb begin
    set_pend = '0;
    for (int i = 1; i <= NS; i++) begin
      cnt_next[i] = '0;
      if (EDGE_MASK[i]) begin
        set_pend[i] = (cnt[i] != '0) && !pending[i] && !inflight[i];
        cnt_next[i] = cnt[i];
        // An edge landing while the counter drains is kept even at saturation.
        if (rise[i] && ((cnt[i] != CNT_MAX) || set_pend[i])) begin
          if (!set_pend[i]) cnt_next[i] = cnt[i] + 1'b1;
        end else if (set_pend[i]) begin
          cnt_next[i] = cnt[i] - 1'b1;
        end
      end else begin
        set_pend[i] = irq_src_i[i] && !pending[i] && !inflight[i];
      end
    end
  end

  // Claim / complete
  always_comb begin
    claim_id  = 5'd0;
    claim_bit = '0;
    done_bit  = '0;
    for (int c = 0; c < NC; c++) begin
      if (bus_sel_i && sel_claim && (hi_ctx == 3'(c))) begin
        if (!bus_we_i) begin
          claim_id = max_id[c];
        end else begin
          for (int i = 1; i <= NS; i++) begin
            if ((bus_wdata_i[4:0] == 5'(i)) && inflight[i] && enable[c][i]) done_bit[i] = 1'b1;
          end
        end
      end
    end
    for (int i = 1; i <= NS; i++) begin
      claim_bit[i] = (claim_id == 5'(i));
    end
  end

  // Read mux
  always_comb begin
    rdata_next = '0;
    if (sel_pend) rdata_next = 32'({pending, 1'b0});
    for (int i = 1; i <= NS; i++) begin
      if (sel_prio && (prio_idx == 10'(i))) rdata_next = 32'(prio[i]);
    end
    for (int c = 0; c < NC; c++) begin
      if (sel_en && (en_ctx == 5'(c)))     rdata_next = 32'({enable[c], 1'b0});
      if (sel_thr && (hi_ctx == 3'(c)))    rdata_next = 32'(thr[c]);
      if (sel_claim && (hi_ctx == 3'(c)))  rdata_next = 32'(max_id[c]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_ack_o   <= 1'b0;
      bus_rdata_o <= '0;
      irq_o       <= '0;
      pending     <= '0;
      inflight    <= '0;
      src_q       <= '0;
      for (int i = 1; i <= NS; i++) begin
        prio[i] <= '0;
        cnt[i]  <= '0;
      end
      for (int c = 0; c < NC; c++) begin
        enable[c] <= '0;
        thr[c]    <= '0;
        max_id[c] <= '0;
      end
    end else begin
      bus_ack_o   <= bus_sel_i;
      bus_rdata_o <= bus_sel_i ? rdata_next : 32'd0;
      src_q       <= irq_src_i[NS:1];
      pending     <= (pending | set_pend) & ~claim_bit;
      inflight    <= (inflight | claim_bit) & ~done_bit;
      for (int i = 1; i <= NS; i++) begin
        cnt[i] <= cnt_next[i];
        if (bus_sel_i && bus_we_i && sel_prio && (prio_idx == 10'(i)))
          prio[i] <= bus_wdata_i[PRIO_W-1:0];
      end
      for (int c = 0; c < NC; c++) begin
        max_id[c] <= win_id[c];
        irq_o[c]  <= (win_id[c] != 5'd0);
        if (bus_sel_i && bus_we_i && sel_en && (en_ctx == 5'(c)))
          enable[c] <= bus_wdata_i[NS:1];
        if (bus_sel_i && bus_we_i && sel_thr && (hi_ctx == 3'(c)))
          thr[c] <= bus_wdata_i[PRIO_W-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_plic_mc_core.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_plic_mc_core : scoreboard bench for plic_mc_core (2 contexts, source 5 edge)
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_plic_mc_core;

  localparam int NS = 6;
  localparam int NC = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NS:0]   irq_src = '0;
  logic          bus_sel = 1'b0;
  logic          bus_we = 1'b0;
  logic [23:0]   bus_addr = '0;
  logic [31:0]   bus_wdata = '0;
  logic [31:0]   bus_rdata;
  logic          bus_ack;
  logic [NC-1:0] irq;

  plic_mc_core #(
    .NUM_SOURCES (NS),
    .NUM_CONTEXTS(NC),
    .PRIO_W      (3),
    .EDGE_MASK   (32'h20),
    .EDGE_CNT_W  (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .irq_src_i  (irq_src),
    .bus_sel_i  (bus_sel),
    .bus_we_i   (bus_we),
    .bus_addr_i (bus_addr),
    .bus_wdata_i(bus_wdata),
    .bus_rdata_o(bus_rdata),
    .bus_ack_o  (bus_ack),
    .irq_o      (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
    bit          chk;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Every ack consumes one scoreboard entry; reads compare data.
  always @(negedge clk) begin
    if (bus_ack === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ack", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.chk) check(e.tag, bus_rdata, e.val);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_rd(input logic [23:0] a, input logic [31:0] e, input string tag);
    exp_q.push_back('{tag, e, 1'b1});
    bus_sel = 1'b1; bus_we = 1'b0; bus_addr = a;
    tick(1);
    bus_sel = 1'b0;
  endtask

  task automatic bus_wr(input logic [23:0] a, input logic [31:0] d);
    exp_q.push_back('{"wr", 32'd0, 1'b0});
    bus_sel = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdata = d;
    tick(1);
    bus_sel = 1'b0; bus_we = 1'b0;
  endtask

  task automatic pulse5();
    irq_src[5] = 1'b1;
    tick(1);
    irq_src[5] = 1'b0;
    tick(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tick(3);
    reset = 1'b0;
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_ack", 32'(bus_ack), 32'd0);
    check("rst_rdata", bus_rdata, 32'd0);

    // Level assert, claim, complete with source still high
    bus_wr(24'h00000C, 32'd2);
    bus_wr(24'h002000, 32'h8);
    bus_wr(24'h200000, 32'd0);
    irq_src[3] = 1'b1;
    tick(1);
    check("lvl_irq_1cyc", 32'(irq), 32'd0);
    tick(1);
    check("lvl_irq_2cyc", 32'(irq), 32'd1);
    bus_rd(24'h200004, 32'd3, "lvl_claim");
    tick(1);
    check("lvl_irq_drop", 32'(irq), 32'd0);
    bus_wr(24'h200004, 32'd3);
    tick(2);
    check("lvl_irq_repend", 32'(irq), 32'd1);
    irq_src[3] = 1'b0;
    bus_rd(24'h200004, 32'd3, "lvl_claim2");
    bus_wr(24'h200004, 32'd3);

    // Threshold and priority ordering
    bus_wr(24'h000004, 32'd5);
    bus_wr(24'h000008, 32'd5);
    bus_wr(24'h000010, 32'd6);
    bus_wr(24'h200000, 32'd5);
    bus_wr(24'h002000, 32'h16);
    irq_src = 7'h16;
    tick(3);
    bus_rd(24'h200004, 32'd4, "thr_claim_4");
    tick(1);
    bus_rd(24'h200004, 32'd0, "thr_claim_none");
    irq_src = 7'h06;
    bus_wr(24'h200004, 32'd4);
    bus_wr(24'h200000, 32'd4);
    tick(2);
    bus_rd(24'h200004, 32'd1, "tie_claim_1");
    tick(1);
    bus_rd(24'h200004, 32'd2, "tie_claim_2");
    irq_src = '0;
    bus_wr(24'h200004, 32'd1);
    bus_wr(24'h200004, 32'd2);

    // Edge counting with saturation
    bus_wr(24'h000014, 32'd3);
    bus_wr(24'h002000, 32'h20);
    bus_wr(24'h200000, 32'd0);
    pulse5();
    tick(2);
    check("edge_irq", 32'(irq), 32'd1);
    bus_rd(24'h200004, 32'd5, "edge_claim_first");
    for (int k = 0; k < 4; k++) pulse5();
    bus_wr(24'h200004, 32'd5);
    for (int k = 0; k < 3; k++) begin
      tick(3);
      bus_rd(24'h200004, 32'd5, $sformatf("edge_repend_%0d", k));
      bus_wr(24'h200004, 32'd5);
    end
    tick(3);
    bus_rd(24'h200004, 32'd0, "edge_saturated");
    bus_rd(24'h001000, 32'd0, "edge_pend_empty");

    // Multi-context
    bus_wr(24'h000008, 32'd1);
    bus_wr(24'h002000, 32'h4);
    bus_wr(24'h002080, 32'h4);
    irq_src[2] = 1'b1;
    tick(3);
    check("mc_both_irq", 32'(irq), 32'd3);
    bus_rd(24'h200004, 32'd2, "mc_claim_c0");
    tick(1);
    check("mc_irq_drop", 32'(irq), 32'd0);
    bus_rd(24'h201004, 32'd0, "mc_claim_c1");
    bus_wr(24'h002080, 32'h0);
    bus_wr(24'h201004, 32'd2);
    tick(3);
    check("mc_bad_complete", 32'(irq), 32'd0);
    bus_rd(24'h001000, 32'd0, "mc_pend_inflight");
    bus_wr(24'h200004, 32'd2);
    tick(3);
    check("mc_c0_repend", 32'(irq), 32'd1);
    irq_src[2] = 1'b0;
    bus_rd(24'h200004, 32'd2, "mc_claim_c0b");
    bus_wr(24'h200004, 32'd2);
    bus_wr(24'h002000, 32'h0);

    // Bus corner cases
    irq_src = 7'h42;
    tick(2);
    irq_src = '0;
    bus_rd(24'h001000, 32'h42, "pend_word");
    bus_wr(24'h001000, 32'h0);
    bus_rd(24'h001000, 32'h42, "pend_ro");
    bus_wr(24'h000004, 32'hFF);
    bus_rd(24'h000004, 32'h7, "prio_trunc");
    bus_rd(24'h300000, 32'h0, "unmapped");
    bus_rd(24'h000000, 32'h0, "prio0");
    tick(1);
    bus_rd(24'h000018, 32'h0, "b2b_first");
    check("b2b_ack1", 32'(bus_ack), 32'd1);
    bus_rd(24'h002080, 32'h0, "b2b_second");
    check("b2b_ack2", 32'(bus_ack), 32'd1);
    tick(1);
    check("b2b_ack_end", 32'(bus_ack), 32'd0);

    // Reset in the middle of a claim
    bus_wr(24'h002000, 32'h42);
    tick(2);
    check("pre_rst_irq", 32'(irq), 32'd1);
    bus_sel = 1'b1; bus_we = 1'b0; bus_addr = 24'h200004;
    reset = 1'b1;
    tick(1);
    check("rst_claim_ack", 32'(bus_ack), 32'd0);
    check("rst_claim_irq", 32'(irq), 32'd0);
    bus_sel = 1'b0;
    reset = 1'b0;
    tick(1);
    bus_rd(24'h001000, 32'h0, "post_rst_pend");
    bus_rd(24'h000004, 32'h0, "post_rst_prio");
    tick(3);
    check("post_rst_irq", 32'(irq), 32'd0);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
